// File: rtl/jtframe_dpram_clr.sv
// Single-clock true dual-port RAM with byte enables, A-over-B write collisions
// and a fill engine that clears the array after reset or on request.
// Optional per-lane even parity: define JTFRAME_RAM_PARITY_EN.
module jtframe_dpram_clr #(
    parameter int unsigned   dw         = 16,
    parameter int unsigned   aw         = 10,
    parameter int unsigned   cen_rd     = 0,
    parameter logic [dw-1:0] fill       = '0,
    parameter int unsigned   clr_on_rst = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [aw-1:0]     addr_a,
    input  logic [dw-1:0]     data_a,
    input  logic [dw/8-1:0]   we_a,
    output logic [dw-1:0]     q_a,
    input  logic [aw-1:0]     addr_b,
    input  logic [dw-1:0]     data_b,
    input  logic [dw/8-1:0]   we_b,
    output logic [dw-1:0]     q_b,
    input  logic              clr,
    output logic              busy,
    output logic              perr_a,
    output logic              perr_b
);

    localparam int unsigned bw    = dw / 8;
    localparam int unsigned depth = 1 << aw;
`ifdef JTFRAME_RAM_PARITY_EN
    localparam int unsigned mw    = dw + bw;
`else
    localparam int unsigned mw    = dw;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [aw:0]     cnt, cnt_nxt, cnt_inc;
    logic            fill_we;
    logic [bw-1:0]   wr_a, wr_b;
    logic            rd_a, rd_b;
    logic [mw-1:0]   mem [depth];
    logic [mw-1:0]   rdw_a, rdw_b;

    // Word as stored in the array: data plus one even-parity bit per lane when enabled
    function automatic logic [mw-1:0] encode(input logic [dw-1:0] d);
`ifdef JTFRAME_RAM_PARITY_EN
        logic [bw-1:0] par;
        par = '0;
        for (int i = 0; i < int'(bw); i++) par[i] = ^d[8*i +: 8];
        return {par, d};
`else
        return d;
`endif
    endfunction

`ifdef JTFRAME_RAM_PARITY_EN
    function automatic logic par_err(input logic [mw-1:0] w);
        logic err;
        err = 1'b0;
        for (int i = 0; i < int'(bw); i++) err = err | (w[dw+i] != ^w[8*i +: 8]);
        return err;
    endfunction
`endif

    // State register; busy mirrors the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (clr_on_rst != 0) ? CLEAR : IDLE;
            cnt   <= '0;
            busy  <= (clr_on_rst != 0);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == CLEAR);
        end
    end

    // Next state: the counter MSB flags the wrap past the last address
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + (aw+1)'(1);
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (clr) begin
                    cnt_nxt = '0;
                end else if (cnt_inc[aw]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Array access controls: the fill engine owns the array while clearing
    always_comb begin
        fill_we = 1'b0;
        wr_a    = '0;
        wr_b    = '0;
        rd_a    = 1'b0;
        rd_b    = 1'b0;
        if (state == CLEAR) begin
            fill_we = 1'b1;
        end else begin
            if (cen) begin
                wr_a = we_a;
                wr_b = we_b;
            end
            rd_a = (cen_rd == 0) || cen;
            rd_b = (cen_rd == 0) || cen;
        end
    end

    // Port B lanes first so port A wins any lane both ports write
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt[aw-1:0]] <= encode(fill);
        end else begin
            for (int i = 0; i < int'(bw); i++) begin
                if (wr_b[i]) begin
                    mem[addr_b][8*i +: 8] <= data_b[8*i +: 8];
`ifdef JTFRAME_RAM_PARITY_EN
                    mem[addr_b][dw+i] <= ^data_b[8*i +: 8];
`endif
                end
            end
            for (int i = 0; i < int'(bw); i++) begin
                if (wr_a[i]) begin
                    mem[addr_a][8*i +: 8] <= data_a[8*i +: 8];
`ifdef JTFRAME_RAM_PARITY_EN
                    mem[addr_a][dw+i] <= ^data_a[8*i +: 8];
`endif
                end
            end
        end
    end

    assign rdw_a = mem[addr_a];
    assign rdw_b = mem[addr_b];

    // Registered read ports; old data is returned on a same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a    <= '0;
            q_b    <= '0;
            perr_a <= 1'b0;
            perr_b <= 1'b0;
        end else if (state == CLEAR) begin
            perr_a <= 1'b0;
            perr_b <= 1'b0;
        end else begin
            if (rd_a) begin
                q_a <= rdw_a[dw-1:0];
`ifdef JTFRAME_RAM_PARITY_EN
                perr_a <= par_err(rdw_a);
`else
                perr_a <= 1'b0;
`endif
            end
            if (rd_b) begin
                q_b <= rdw_b[dw-1:0];
`ifdef JTFRAME_RAM_PARITY_EN
                perr_b <= par_err(rdw_b);
`else
                perr_b <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_jtframe_dpram_clr.sv
// Testbench for jtframe_dpram_clr: directed steps plus random traffic checked
// against an array model of the RAM contents and read registers.
module tb_jtframe_dpram_clr;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] FILL  = 16'hA5A5;

    logic        clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0, cen = 1'b0, clr = 1'b0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic [1:0]  we_a = '0, we_b = '0;
    logic [15:0] q_a, q_b, q_a1, q_b1;
    logic        busy, busy1, perr_a, perr_b, perr_a1, perr_b1;

    int          checks = 0, errors = 0;
    int          n;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref1    [DEPTH];
    logic [15:0] exp_qa = '0, exp_qb = '0;

    always #5 clk = ~clk;

    jtframe_dpram_clr #(.dw(16), .aw(4), .cen_rd(1), .fill(FILL), .clr_on_rst(1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b),
        .clr(clr), .busy(busy), .perr_a(perr_a), .perr_b(perr_b)
    );

    jtframe_dpram_clr #(.dw(16), .aw(4), .cen_rd(0), .fill(FILL), .clr_on_rst(0)) dut1 (
        .clk(clk), .rst_n(rst1_n), .cen(cen),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a1),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b1),
        .clr(clr), .busy(busy1), .perr_a(perr_a1), .perr_b(perr_b1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] we);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One idle-state cycle on dut; the model reads old contents, then B writes, then A
    task automatic step(input logic [3:0] aa, input logic [15:0] da, input logic [1:0] wa,
                        input logic [3:0] ab, input logic [15:0] db, input logic [1:0] wb,
                        input logic c);
        addr_a = aa; data_a = da; we_a = wa;
        addr_b = ab; data_b = db; we_b = wb;
        cen = c;
        if (c) begin
            exp_qa = ref_mem[aa];
            exp_qb = ref_mem[ab];
            ref_mem[ab] = merge(ref_mem[ab], db, wb);
            ref_mem[aa] = merge(ref_mem[aa], da, wa);
        end
        tick;
        chk("q_a", q_a, exp_qa);
        chk("q_b", q_b, exp_qb);
        chk("perr", {14'd0, perr_a, perr_b}, 16'd0);
        chk("busy_idle", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) tick;
        chk("rst_q_a", q_a, 16'd0);
        chk("rst_q_b", q_b, 16'd0);
        chk("rst_perr", {14'd0, perr_a, perr_b}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd1);
        chk("rst_busy_noauto", {15'd0, busy1}, 16'd0);

        // Power-on clear lasts exactly DEPTH cycles
        rst_n = 1'b1; rst1_n = 1'b1;
        n = 0;
        do begin tick; n++; end while (busy && n < 100);
        chk("poweron_busy_cycles", 16'(n), 16'd16);
        chk("noauto_busy", {15'd0, busy1}, 16'd0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = FILL;
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(4'(i), 16'd0, 2'b00, 4'(15 - i), 16'd0, 2'b00, 1'b1);
            chk("poweron_fill_a", q_a, FILL);
            chk("poweron_fill_b", q_b, FILL);
        end

        // Byte enables
        step(4'd3, 16'h1234, 2'b11, 4'd0, 16'd0, 2'b00, 1'b1);
        step(4'd3, 16'hFF00, 2'b10, 4'd0, 16'd0, 2'b00, 1'b1);
        step(4'd3, 16'd0, 2'b00, 4'd3, 16'd0, 2'b00, 1'b1);
        chk("byte_enable", q_a, 16'hFF34);

        // Collision: A owns lane 0, B alone writes lane 1
        step(4'd5, 16'hAAAA, 2'b01, 4'd5, 16'hBBBB, 2'b11, 1'b1);
        step(4'd5, 16'd0, 2'b00, 4'd5, 16'd0, 2'b00, 1'b1);
        chk("collision", q_a, 16'hBBAA);

        // Read during write returns old data
        step(4'd7, 16'h0001, 2'b11, 4'd0, 16'd0, 2'b00, 1'b1);
        step(4'd7, 16'h0002, 2'b11, 4'd7, 16'd0, 2'b00, 1'b1);
        chk("rdw_old", q_b, 16'h0001);
        step(4'd0, 16'd0, 2'b00, 4'd7, 16'd0, 2'b00, 1'b1);
        chk("rdw_new", q_b, 16'h0002);

        // cen gating with cen_rd=1
        step(4'd3, 16'h5555, 2'b11, 4'd9, 16'h5555, 2'b11, 1'b0);
        chk("cen_hold_a", q_a, FILL);
        step(4'd12, 16'd0, 2'b00, 4'd1, 16'd0, 2'b00, 1'b0);
        chk("cen_hold_a2", q_a, FILL);
        step(4'd3, 16'd0, 2'b00, 4'd3, 16'd0, 2'b00, 1'b1);
        chk("cen_no_write", q_a, 16'hFF34);

        // Random traffic
        repeat (300)
            step(4'($urandom), 16'($urandom), 2'($urandom),
                 4'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));

        // Clear restarted by clr at cycle 8: busy for 8+16 cycles, writes ignored
        we_a = '0; we_b = '0; cen = 1'b0; clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_busy", {15'd0, busy}, 16'd1);
        n = 0;
        repeat (7) begin
            addr_a = 4'($urandom); data_a = 16'($urandom); we_a = 2'b11; cen = 1'b1;
            tick; n++;
            chk("clr_q_hold", q_a, exp_qa);
            chk("clr_perr", {15'd0, perr_a}, 16'd0);
        end
        clr = 1'b1;
        tick; n++;
        clr = 1'b0;
        while (busy && n < 200) begin tick; n++; end
        chk("restart_busy_cycles", 16'(n), 16'd24);
        we_a = '0; cen = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = FILL;
        for (int i = 0; i < int'(DEPTH); i++)
            step(4'(i), 16'd0, 2'b00, 4'(i ^ 5), 16'd0, 2'b00, 1'b1);

        // Reset mid-clear on the no-auto-clear instance
        for (int i = 0; i < int'(DEPTH); i++)
            step(4'(i), 16'($urandom), 2'b11, 4'(i), 16'd0, 2'b00, 1'b1);
        foreach (ref1[i]) ref1[i] = ref_mem[i];
        cen = 1'b0; we_a = '0; clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (5) tick;
        chk("abort_busy_before", {15'd0, busy1}, 16'd1);
        rst1_n = 1'b0;
        for (int i = 0; i < 5; i++) ref1[i] = FILL;
        tick;
        chk("abort_busy_rst", {15'd0, busy1}, 16'd0);
        chk("abort_q_rst", q_a1, 16'd0);
        rst1_n = 1'b1;
        tick;
        chk("abort_busy_after", {15'd0, busy1}, 16'd0);
        n = 0;
        while (busy && n < 100) begin tick; n++; end
        chk("abort_dut0_done", {15'd0, busy}, 16'd0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = FILL;
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(4'(i), 16'd0, 2'b00, 4'(15 - i), 16'd0, 2'b00, 1'b1);
            chk("abort_partial_a", q_a1, ref1[i]);
            chk("abort_partial_b", q_b1, ref1[15 - i]);
        end

`ifdef JTFRAME_RAM_PARITY_EN
        // Corrupt one stored data bit and expect a parity error on read
        dut.mem[2][0] = ~dut.mem[2][0];
        addr_a = 4'd2; cen = 1'b1;
        tick;
        chk("parity_error", {15'd0, perr_a}, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
